// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between decode/register-read, the ALU and writeback.
// The master drives operands and consumes results; the slave is the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             err;

  modport master (
    output in_valid, in_1, in_2, op, out_ready,
    input  in_ready, out_valid, out_res, flag_z, flag_n, flag_c, flag_v, err
  );

  modport slave (
    input  in_valid, in_1, in_2, op, out_ready,
    output in_ready, out_valid, out_res, flag_z, flag_n, flag_c, flag_v, err
  );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake and Z/N/C/V flags.
// Define ALU_PIPE_MUL_EN to build op 1100 as a WIDTH-cycle shift-add multiplier.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  localparam logic [3:0] OP_A   = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_INC = 4'b0101;
  localparam logic [3:0] OP_DEC = 4'b0110;
  localparam logic [3:0] OP_B   = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_SHR = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;

  logic             accept;
  logic             single_accept;
  logic             mul_done;
  logic [WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum;
  logic             res_c;
  logic             res_v;
  logic             res_err;
  logic [SHW-1:0]   sh;

  assign accept = bus.in_valid && bus.in_ready;
  assign sh     = bus.in_2[SHW-1:0];

  // Single-cycle datapath; anything not listed (including 1100 here) reports err with res=0.
  always_comb begin
    res     = '0;
    sum     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_err = 1'b0;
    case (bus.op)
      OP_A: res = bus.in_1;
      OP_ADD: begin
        sum   = {1'b0, bus.in_1} + {1'b0, bus.in_2};
        res   = sum[MSB:0];
        res_c = sum[WIDTH];
        res_v = (bus.in_1[MSB] == bus.in_2[MSB]) && (res[MSB] != bus.in_1[MSB]);
      end
      OP_SUB: begin
        sum   = {1'b0, bus.in_1} - {1'b0, bus.in_2};
        res   = sum[MSB:0];
        res_c = sum[WIDTH];
        res_v = (bus.in_1[MSB] != bus.in_2[MSB]) && (res[MSB] != bus.in_1[MSB]);
      end
      OP_AND: res = bus.in_1 & bus.in_2;
      OP_OR:  res = bus.in_1 | bus.in_2;
      OP_INC: begin
        sum   = {1'b0, bus.in_1} + ONE;
        res   = sum[MSB:0];
        res_c = sum[WIDTH];
        res_v = !bus.in_1[MSB] && res[MSB];
      end
      OP_DEC: begin
        sum   = {1'b0, bus.in_1} - ONE;
        res   = sum[MSB:0];
        res_c = sum[WIDTH];
        res_v = bus.in_1[MSB] && !res[MSB];
      end
      OP_B:   res = bus.in_2;
      OP_XOR: res = bus.in_1 ^ bus.in_2;
      OP_SHL: res = bus.in_1 << sh;
      OP_SHR: res = bus.in_1 >> sh;
      OP_SRA: res = WIDTH'($signed(bus.in_1) >>> sh);
      default: res_err = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  state_t           next_state;
  logic             mul_start;
  logic [SHW:0]     count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;

  assign mul_res       = acc + (b_sh[0] ? a_sh : '0);
  assign bus.in_ready  = (state == IDLE) && (!bus.out_valid || bus.out_ready);
  assign single_accept = accept && (bus.op != OP_MUL);

  always_comb begin
    next_state = state;
    mul_start  = 1'b0;
    mul_done   = 1'b0;
    case (state)
      IDLE: if (accept && bus.op == OP_MUL) begin
        next_state = MUL;
        mul_start  = 1'b1;
      end
      MUL: if (count == CNT_LAST) begin
        next_state = IDLE;
        mul_done   = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // One partial product per cycle; the last step is folded into mul_res so the
  // result lands on the same edge the count expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
    end else begin
      state <= next_state;
      if (mul_start) begin
        a_sh  <= bus.in_1;
        b_sh  <= bus.in_2;
        acc   <= '0;
        count <= CNT_INIT;
      end else if (state == MUL) begin
        acc   <= mul_res;
        a_sh  <= a_sh << 1;
        b_sh  <= b_sh >> 1;
        count <= count - 1'b1;
      end
    end
  end
`else
  assign bus.in_ready  = !bus.out_valid || bus.out_ready;
  assign single_accept = accept;
  assign mul_done      = 1'b0;
  assign mul_res       = '0;
`endif

  // Output slot: holds its contents until writeback takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_res   <= '0;
      bus.flag_z    <= 1'b0;
      bus.flag_n    <= 1'b0;
      bus.flag_c    <= 1'b0;
      bus.flag_v    <= 1'b0;
      bus.err       <= 1'b0;
    end else if (mul_done) begin
      bus.out_valid <= 1'b1;
      bus.out_res   <= mul_res;
      bus.flag_z    <= (mul_res == '0);
      bus.flag_n    <= mul_res[MSB];
      bus.flag_c    <= 1'b0;
      bus.flag_v    <= 1'b0;
      bus.err       <= 1'b0;
    end else if (single_accept) begin
      bus.out_valid <= 1'b1;
      bus.out_res   <= res;
      bus.flag_z    <= (res == '0);
      bus.flag_n    <= res[MSB];
      bus.flag_c    <= res_c;
      bus.flag_v    <= res_v;
      bus.err       <= res_err;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, handshake sequences, random ops
// against an arithmetic reference model, and reset during a multiply.
module tb_alu_pipe;
  localparam int W = 32;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];
  logic [31:0] pool [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  function automatic vec_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] res, logic [4:0] zncve);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.res = res;
    {t.z, t.n, t.c, t.v, t.err} = zncve;
    return t;
  endfunction

  // Reference: plain wide/signed arithmetic, flags from the mathematical result.
  function automatic vec_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    vec_t   t;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    logic [63:0] p;
    t.op = op; t.a = a; t.b = b;
    t.res = 32'h0; t.c = 1'b0; t.v = 1'b0; t.err = 1'b0;
    case (op)
      4'h0: t.res = a;
      4'h1, 4'h5: begin
        if (op == 4'h5) sb = 1;
        p = 64'(a) + 64'(sb[31:0]);
        t.res = p[31:0];
        t.c = p[32];
        s = sa + sb;
        t.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h2, 4'h6: begin
        if (op == 4'h6) sb = 1;
        t.res = a - sb[31:0];
        t.c = (a < sb[31:0]);
        s = sa - sb;
        t.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h3: t.res = a & b;
      4'h4: t.res = a | b;
      4'h7: t.res = b;
      4'h8: t.res = a ^ b;
      4'h9: t.res = a << b[4:0];
      4'hA: t.res = a >> b[4:0];
      4'hB: begin
        s = sa >>> b[4:0];
        t.res = s[31:0];
      end
`ifdef ALU_PIPE_MUL_EN
      4'hC: begin
        p = 64'(a) * 64'(b);
        t.res = p[31:0];
      end
`endif
      default: t.err = 1'b1;
    endcase
    t.z = (t.res == 32'h0);
    t.n = t.res[31];
    return t;
  endfunction

  function automatic int exp_latency(logic [3:0] op);
`ifdef ALU_PIPE_MUL_EN
    if (op == 4'hC) return W;
`endif
    return 0;
  endfunction

  task automatic check_val(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_output(string name, vec_t e);
    check_val(name, {26'h0, bus.out_res, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.err},
              {26'h0, e.res, e.z, e.n, e.c, e.v, e.err});
  endtask

  // One full transaction with out_ready high; checks latency, busy window and result.
  task automatic apply_stimulus(string name, vec_t e);
    int waited = 0;
    int lat = 0;
    int ready_seen = 0;
    int elat = exp_latency(e.op);
    @(negedge clk);
    bus.out_ready = 1'b1;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL %s accept: in_ready stuck at 0, required 1", name);
      return;
    end
    bus.in_valid = 1'b1;
    bus.op = e.op;
    bus.in_1 = e.a;
    bus.in_2 = e.b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) ready_seen++;
      @(negedge clk);
      lat++;
    end
    check_val({name, " latency"}, 64'(lat), 64'(elat));
    if (bus.out_valid) check_output(name, e);
    if (elat > 0) check_val({name, " busy in_ready"}, 64'(ready_seen), 64'h0);
  endtask

  initial begin
    int cnt;
    vec_t r;
    logic [31:0] ra, rb;
    logic [3:0]  rop;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 4'h0;
    bus.in_1 = 32'h0;
    bus.in_2 = 32'h0;
    rst_n = 1'b0;
    #1;
    check_val("reset outputs", {bus.out_valid, bus.out_res, bus.flag_z, bus.flag_n,
              bus.flag_c, bus.flag_v, bus.err}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("in_ready after reset", 64'(bus.in_ready), 64'h1);

    vecs.push_back(mk(4'h1, 32'hFFFFFFFF, 32'h1,        32'h00000000, 5'b10100));
    vecs.push_back(mk(4'h1, 32'h80000000, 32'h80000000, 32'h00000000, 5'b10110));
    vecs.push_back(mk(4'h2, 32'h80000000, 32'h1,        32'h7FFFFFFF, 5'b00010));
    vecs.push_back(mk(4'h2, 32'h3,        32'h5,        32'hFFFFFFFE, 5'b01100));
    vecs.push_back(mk(4'hB, 32'h80000010, 32'h24,       32'hF8000001, 5'b01000));
    vecs.push_back(mk(4'h9, 32'h1,        32'h1F,       32'h80000000, 5'b01000));
    vecs.push_back(mk(4'hA, 32'h80000000, 32'h21,       32'h40000000, 5'b00000));
    vecs.push_back(mk(4'h0, 32'h12345678, 32'h9,        32'h12345678, 5'b00000));
    vecs.push_back(mk(4'h7, 32'h9,        32'hABCD0000, 32'hABCD0000, 5'b01000));
    vecs.push_back(mk(4'h3, 32'hF0F0,     32'hFF00,     32'h0000F000, 5'b00000));
    vecs.push_back(mk(4'h4, 32'hF0F0,     32'h0F0F,     32'h0000FFFF, 5'b00000));
    vecs.push_back(mk(4'h8, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 5'b00000));
    vecs.push_back(mk(4'h5, 32'h7FFFFFFF, 32'h0,        32'h80000000, 5'b01010));
    vecs.push_back(mk(4'h5, 32'hFFFFFFFF, 32'h0,        32'h00000000, 5'b10100));
    vecs.push_back(mk(4'h6, 32'h0,        32'h0,        32'hFFFFFFFF, 5'b01100));
    vecs.push_back(mk(4'h6, 32'h80000000, 32'h0,        32'h7FFFFFFF, 5'b00010));
    vecs.push_back(mk(4'hD, 32'h1,        32'h2,        32'h00000000, 5'b10001));
    vecs.push_back(mk(4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5'b10001));
`ifdef ALU_PIPE_MUL_EN
    vecs.push_back(mk(4'hC, 32'h00010003, 32'h5,        32'h0005000F, 5'b00000));
`else
    vecs.push_back(mk(4'hC, 32'h00010003, 32'h5,        32'h00000000, 5'b10001));
`endif
    foreach (vecs[i]) apply_stimulus($sformatf("vec%0d op%h", i, vecs[i].op), vecs[i]);

    // Stalled writeback: second op must wait until the first result is taken.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.op = 4'h1; bus.in_1 = 32'd2; bus.in_2 = 32'd3;
    @(negedge clk);
    bus.op = 4'h4; bus.in_1 = 32'd1; bus.in_2 = 32'd2;
    check_val("bp first result", {bus.out_valid, bus.out_res}, {1'b1, 32'd5});
    check_val("bp in_ready low", 64'(bus.in_ready), 64'h0);
    @(negedge clk);
    check_val("bp held result", {bus.out_valid, bus.out_res}, {1'b1, 32'd5});
    check_val("bp still blocked", 64'(bus.in_ready), 64'h0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_val("bp second result", {bus.out_valid, bus.out_res}, {1'b1, 32'd3});
    @(negedge clk);
    check_val("bp drained", 64'(bus.out_valid), 64'h0);

    // Full throughput: one result per cycle.
    bus.in_valid = 1'b1; bus.op = 4'h1; bus.in_1 = 32'd2; bus.in_2 = 32'd3;
    @(negedge clk);
    check_val("tp r0", {bus.out_valid, bus.out_res}, {1'b1, 32'd5});
    bus.op = 4'h4; bus.in_1 = 32'd1; bus.in_2 = 32'd2;
    @(negedge clk);
    check_val("tp r1", {bus.out_valid, bus.out_res}, {1'b1, 32'd3});
    bus.op = 4'h8; bus.in_1 = 32'hF0; bus.in_2 = 32'h0F;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_val("tp r2", {bus.out_valid, bus.out_res}, {1'b1, 32'hFF});
    @(negedge clk);
    check_val("tp drained", 64'(bus.out_valid), 64'h0);

    for (int i = 0; i < 120; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : 32'($urandom);
      r = model(rop, ra, rb);
      apply_stimulus($sformatf("rnd%0d op%h a=%h b=%h", i, rop, ra, rb), r);
    end

    // Reset in the middle of a multiply, with the consumer stalled.
    @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.op = 4'hC; bus.in_1 = 32'h00010003; bus.in_2 = 32'h5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("reset mid-op out_valid", 64'(bus.out_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("reset mid-op in_ready", 64'(bus.in_ready), 64'h1);
    apply_stimulus("post-reset add", model(4'h1, 32'd7, 32'd8));
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check_val("no stale mul result", 64'(cnt), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
